// File: rtl/muldiv_pkg.sv
// Shared M-extension definitions: funct3 encodings, divider FSM states, default width.
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [2:0] FUNCT3_DIV  = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU = 3'b101;
   localparam logic [2:0] FUNCT3_REM  = 3'b110;
   localparam logic [2:0] FUNCT3_REMU = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } div_state_e;

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One radix-2 restoring divide step: trial subtract, then keep or restore.
// Kept separate so the subtract path is its own timing cone and can be
// chained twice for a radix-4 variant.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic            dvd_bit,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_nxt,
   output logic            q_bit
);

   logic [XLEN:0] trial;

   // XLEN+1 wide so the borrow lands in the top bit.
   assign trial   = {rem, dvd_bit} - {1'b0, divisor};
   assign q_bit   = ~trial[XLEN];
   // On success the difference is always below the divisor, so it fits in XLEN bits.
   assign rem_nxt = q_bit ? trial[XLEN-1:0] : {rem[XLEN-2:0], dvd_bit};

endmodule

// File: rtl/muldiv_seq_div.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit, one quotient bit per cycle,
// valid/ready on both sides. Divide-by-zero and signed overflow finish in one cycle.
module muldiv_seq_div
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic [2:0]      funct3_i,
   input  logic            flush_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] q;        // dividend bits shift out of the top, quotient bits in at the bottom
   logic [XLEN-1:0] rem_r;
   logic [XLEN-1:0] dvs;
   logic [XLEN-1:0] result;
   logic            is_rem, neg_q, neg_r;

   // Request decode (funct3 bit 2 only distinguishes M ops from the multiplier).
   logic            sgn, op_rem, div0, ovf;
   logic [XLEN-1:0] a_abs, b_abs;
   logic            unused_funct3;

   assign unused_funct3 = funct3_i[2];
   assign sgn    = ~funct3_i[0];
   assign op_rem = funct3_i[1];
   assign div0   = (divisor_i == '0);
   assign ovf    = sgn && (dividend_i == MIN_NEG) && (divisor_i == '1);
   assign a_abs  = (sgn && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
   assign b_abs  = (sgn && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

   logic [XLEN-1:0] step_rem;
   logic            step_q;

   div_step #(.XLEN(XLEN)) u_step (
      .rem     (rem_r),
      .dvd_bit (q[XLEN-1]),
      .divisor (dvs),
      .rem_nxt (step_rem),
      .q_bit   (step_q)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state; flush overrides accept and response handshake.
   always_comb begin
      state_nxt = state;
      if (flush_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (req_valid_i) state_nxt = (div0 || ovf) ? DONE : CALC;
            CALC:    if (cnt == '0)   state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    if (resp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Operand latch, shift-subtract iteration and sign fixup.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt    <= '0;
         q      <= '0;
         rem_r  <= '0;
         dvs    <= '0;
         result <= '0;
         is_rem <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (flush_i) begin
         result <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid_i) begin
               is_rem <= op_rem;
               neg_q  <= sgn && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
               neg_r  <= sgn && dividend_i[XLEN-1];
               q      <= a_abs;
               dvs    <= b_abs;
               rem_r  <= '0;
               cnt    <= CW'(XLEN-1);
               if (div0)     result <= op_rem ? dividend_i : '1;
               else if (ovf) result <= op_rem ? '0 : MIN_NEG;
            end
            CALC: begin
               rem_r <= step_rem;
               q     <= {q[XLEN-2:0], step_q};
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            FIXUP: begin
               if (is_rem) result <= neg_r ? -rem_r : rem_r;
               else        result <= neg_q ? -q : q;
            end
            DONE: if (resp_ready_i) result <= '0;
            default: ;
         endcase
      end
   end

   assign req_ready_o  = (state == IDLE);
   assign busy_o       = (state != IDLE);
   assign resp_valid_o = (state == DONE);
   assign result_o     = result;

endmodule

// File: tb/tb_muldiv_seq_div.sv
// Directed bench for muldiv_seq_div: values, latency, backpressure, flush, reset.
module tb_muldiv_seq_div;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready;
   logic [31:0] dividend = '0, divisor = '0;
   logic [2:0]  funct3 = 3'b100;
   logic        flush = 1'b0;
   logic        resp_valid, resp_ready = 1'b0;
   logic [31:0] result;
   logic        busy;

   int errors = 0;
   int checks = 0;

   muldiv_seq_div #(.XLEN(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .dividend_i   (dividend),
      .divisor_i    (divisor),
      .funct3_i     (funct3),
      .flush_i      (flush),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .result_o     (result),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request for one edge; returns at the negedge after the accept edge.
   task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      funct3 = f; dividend = a; divisor = b; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
   endtask

   // Count edges from accept (accept edge = 1) until resp_valid; bounded.
   task automatic wait_resp(input string tag, output int n);
      bit rdy_seen = 1'b0;
      n = 1;
      while (!resp_valid && n < 100) begin
         if (req_ready) rdy_seen = 1'b1;
         @(posedge clk); @(negedge clk);
         n++;
      end
      chk({tag, "_ready_low"}, {31'd0, rdy_seen}, 32'd0);
      chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int n;
      resp_ready = 1'b1;
      start(f, a, b);
      wait_resp(tag, n);
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_res"}, result, exp);
      @(posedge clk); @(negedge clk);
      chk({tag, "_idle"}, {30'd0, req_ready, resp_valid}, 32'b10);
   endtask

   initial begin
      int n;
      logic [31:0] held;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_outs", {29'd0, req_ready, resp_valid, busy}, 32'b100);
      chk("rst_result", result, 32'd0);

      // Normal path, 34-cycle latency
      run_op("divu_100_7", FUNCT3_DIVU, 32'd100, 32'd7, 32'd14, 34);
      run_op("remu_100_7", FUNCT3_REMU, 32'd100, 32'd7, 32'd2, 34);
      run_op("div_m7_2",   FUNCT3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      run_op("rem_m7_2",   FUNCT3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      run_op("rem_7_m2",   FUNCT3_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34);
      run_op("div_min_1",  FUNCT3_DIV,  32'h8000_0000, 32'd1, 32'h8000_0000, 34);
      run_op("div_m100_7", FUNCT3_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34);

      // Fast paths
      run_op("divu_by0",   FUNCT3_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("remu_by0",   FUNCT3_REMU, 32'h1234, 32'd0, 32'h1234, 1);
      run_op("div_m5_by0", FUNCT3_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("div_ovf",    FUNCT3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf",    FUNCT3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      run_op("divu_nofast", FUNCT3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

      // Backpressure: hold DONE, wiggle operand inputs
      resp_ready = 1'b0;
      start(FUNCT3_DIVU, 32'd1000, 32'd10);
      wait_resp("bp", n);
      held = result;
      chk("bp_res", held, 32'd100);
      for (int i = 0; i < 5; i++) begin
         dividend = $urandom; divisor = $urandom; funct3 = 3'($urandom);
         req_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         chk("bp_hold", {result[31:2], result[1:0]}, 32'd100);
         chk("bp_flags", {30'd0, resp_valid, req_ready}, 32'b10);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("bp_release", {29'd0, req_ready, resp_valid, busy}, 32'b100);

      // Flush in cycle 10 of CALC
      start(FUNCT3_DIVU, 32'd100, 32'd7);
      repeat (9) begin @(posedge clk); @(negedge clk); end
      chk("fl_busy", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("fl_idle", {29'd0, req_ready, resp_valid, busy}, 32'b100);
      n = 0;
      repeat (40) begin @(posedge clk); @(negedge clk); if (resp_valid) n++; end
      chk("fl_noresp", n, 0);

      // Flush wins over an accept in IDLE
      @(negedge clk);
      funct3 = FUNCT3_DIVU; dividend = 32'd9; divisor = 32'd0;
      req_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("fl_vs_accept", {30'd0, busy, resp_valid}, 32'b00);

      // Flush wins over resp_ready in DONE
      resp_ready = 1'b0;
      start(FUNCT3_DIVU, 32'd5, 32'd0);
      chk("fl_done_pre", {31'd0, resp_valid}, 32'd1);
      flush = 1'b1; resp_ready = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("fl_done", {31'd0, resp_valid}, 32'd0);
      chk("fl_done_res", result, 32'd0);

      // Reset in cycle 20
      start(FUNCT3_DIVU, 32'd100, 32'd7);
      repeat (19) begin @(posedge clk); @(negedge clk); end
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rs_idle", {29'd0, req_ready, resp_valid, busy}, 32'b100);
      chk("rs_result", result, 32'd0);
      n = 0;
      repeat (40) begin @(posedge clk); @(negedge clk); if (resp_valid) n++; end
      chk("rs_noresp", n, 0);

      run_op("divu_ff_3", FUNCT3_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/muldiv_seq_div.md
Name: muldiv_seq_div

Overview:
- Iterative, multi-cycle RISC-V M-extension divider: DIV, DIVU, REM, REMU.
- Radix-2 restoring shift-subtract, one quotient bit per cycle. Handshaked replacement for the single-cycle combinational divide path, so the core can drop the large array divider and stall on busy.
- Sits in EX beside the multiplier. The issue side raises a request and the writeback side consumes a response over a valid/ready pair.

Parameters:
- XLEN, 32, operand/result width; counter width is $clog2(XLEN).

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  reset; synchronous, active-low
- req_valid_i  input  1  division request present
- req_ready_o  output  1  unit can accept a request (high only in IDLE)
- dividend_i  input  XLEN  rs1 value
- divisor_i  input  XLEN  rs2 value
- funct3_i  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; bit 2 ignored
- flush_i  input  1  kill in-flight operation (pipeline flush)
- resp_valid_o  output  1  result available
- resp_ready_i  input  1  consumer takes result
- result_o  output  XLEN  quotient or remainder
- busy_o  output  1  state != IDLE

Behaviour:
- Clock and reset: all state changes on rising clk_i.
  - rst_ni=0 at an edge gives: state=IDLE, counter=0, operand/result regs=0.
  - Outputs after reset: req_ready_o=1, resp_valid_o=0, busy_o=0, result_o=0.
  - Reset mid-operation discards the operation with no response.
- States: IDLE, CALC, FIXUP, DONE (2-bit enum).
- IDLE, on req_valid_i & req_ready_o (the accept edge):
  - Latch op (signed = ~funct3[0], rem = funct3[1]), dividend and divisor.
  - Signed op: latch |dividend| and |divisor|; record neg_q = sign(a)^sign(b) and neg_r = sign(a).
  - Divisor==0: result = rem ? dividend : all-ones; next state DONE.
  - Signed with dividend==1<<(XLEN-1) and divisor==all-ones: result = rem ? 0 : 1<<(XLEN-1); next state DONE.
  - Otherwise: partial remainder=0, counter=XLEN-1, next state CALC.
- CALC, each cycle:
  - trial = {rem[XLEN-1:0], q[XLEN-1]} - {1'b0, divisor}, computed XLEN+1 wide.
  - If trial is non-negative: rem <= trial and shift in quotient bit 1.
  - Otherwise: shift rem left with the next dividend bit and shift in quotient bit 0.
  - Quotient and dividend share one shift register.
  - counter==0 moves to FIXUP; otherwise counter decrements.
- FIXUP:
  - result = rem ? (neg_r ? -r : r) : (neg_q ? -q : q), two's complement at XLEN bits.
  - Next state DONE.
- DONE:
  - resp_valid_o=1 and result_o is held stable until resp_ready_i=1; then next state IDLE.
  - No new request is accepted in the same cycle, so there is one idle cycle between operations.
- Latency, accept edge to resp_valid_o high:
  - XLEN+2 cycles normally (34 for XLEN=32).
  - 1 cycle for the divide-by-zero and overflow fast paths.
- flush_i=1 at an edge in any state:
  - Next state IDLE; resp_valid_o drops and no response is produced.
  - flush_i takes priority over an accept and over resp_ready_i in the same cycle.
  - rst_ni takes priority over flush_i.
- result_o is a register output and reads 0 except in DONE.
- Inputs are sampled only at the accept edge; later changes to the operand inputs are ignored.

Decomposition:
- Shared package muldiv_pkg:
  - FUNCT3_DIV/DIVU/REM/REMU constants, also used by the existing decoder.
  - div_state_e enum {IDLE, CALC, FIXUP, DONE}.
  - XLEN default.
- One combinational sub-module, div_step:
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next remainder and quotient bit.
  - It isolates the subtract path for timing and lets a radix-4 variant instantiate it twice later.
- All sequencing stays in muldiv_seq_div.

Test Plan:
- DIVU 100/7, then REMU 100/7 with resp_ready_i=1 -> results 14 and 2; resp_valid_o rises exactly 34 cycles after each accept; req_ready_o=0 throughout.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. REM 7/-2 -> 1. DIV 0x80000000/1 -> 0x80000000.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; DIV -5/0 -> 0xFFFFFFFF. Each with resp_valid_o high 1 cycle after accept.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both on the 1-cycle fast path.
- Backpressure: hold resp_ready_i=0 for 5 cycles in DONE and toggle operand inputs -> result_o stable, resp_valid_o held, req_ready_o=0. Release -> IDLE next cycle.
- Assert flush_i in cycle 10 of CALC, then separately rst_ni=0 in cycle 20 -> no resp_valid_o, req_ready_o=1 next cycle. A following DIVU 0xFFFFFFFF/3 -> 0x55555555.
